// File: rtl/fetch_if.sv
// ----------------------------------------------------------------------------
// fetch_if: connects the fetch stage to the hazard/branch unit in ID, to the
// instruction memory and to the decoder.
//
//   start_i        fetch enable; 0 freezes fetch
//   PCWrite_i      0 = hold the PC (load-use hazard)
//   Stall_i        1 = hold IF/ID contents
//   Flush_i        branch taken in ID; squash IF/ID and redirect
//   BranchTarget_i redirect address; bits [1:0] ignored
//   instr_i        instruction memory read data for instr_addr_o
//   instr_addr_o   current PC
//   IFID_pc_o      PC of the instruction held in IF/ID
//   IFID_instr_o   instruction held in IF/ID
//   IFID_valid_o   1 = real instruction, 0 = bubble
//   stall_cnt_o    saturating count of stalled cycles
//   flush_cnt_o    saturating count of applied flushes
//
// master: the environment (hazard unit, memory, decoder). slave: fetch_stage.
// ----------------------------------------------------------------------------
interface fetch_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start_i;
  logic             PCWrite_i;
  logic             Stall_i;
  logic             Flush_i;
  logic [31:0]      BranchTarget_i;
  logic [31:0]      instr_i;
  logic [31:0]      instr_addr_o;
  logic [31:0]      IFID_pc_o;
  logic [31:0]      IFID_instr_o;
  logic             IFID_valid_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output start_i, PCWrite_i, Stall_i, Flush_i, BranchTarget_i, instr_i,
    input  instr_addr_o, IFID_pc_o, IFID_instr_o, IFID_valid_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_i, PCWrite_i, Stall_i, Flush_i, BranchTarget_i, instr_i,
    output instr_addr_o, IFID_pc_o, IFID_instr_o, IFID_valid_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage: instruction-fetch front end. Owns the PC and the IF/ID
// pipeline register and applies stall, PC-hold and flush requests from ID.
// Keeps saturating stall and flush event counters.
//
//   clk_i  clock, rising edge
//   rst_i  asynchronous, active-low reset
//   bus    fetch_if.slave (control in, instruction in, IF/ID and counters out)
//
// Parameters:
//   RESET_PC  PC loaded at reset (low two bits forced to 0)
//   CNT_W     width of the stall/flush counters; must match the interface
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic    clk_i,
  input  logic    rst_i,
  fetch_if.slave  bus
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] WORD_MASK = ~32'h0000_0003;

  logic [31:0]      pc_q;
  logic [31:0]      ifid_pc_q;
  logic [31:0]      ifid_instr_q;
  logic             ifid_valid_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // PC+4 wraps naturally modulo 2^32.
  logic [31:0] pc_inc;
  assign pc_inc = pc_q + 32'd4;

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q         <= RESET_PC & WORD_MASK;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else if (!bus.start_i) begin
      // Frozen: PC and counters hold, downstream drains on bubbles.
      ifid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
    end else if (bus.Stall_i) begin
      // Stall wins over flush: the branch was resolved with stale operands.
      if (bus.PCWrite_i) pc_q <= pc_inc;
      if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end else if (bus.Flush_i) begin
      ifid_pc_q    <= pc_q;
      ifid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
      if (bus.PCWrite_i) pc_q <= bus.BranchTarget_i & WORD_MASK;
      if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end else begin
      ifid_pc_q    <= pc_q;
      ifid_instr_q <= bus.instr_i;
      ifid_valid_q <= 1'b1;
      if (bus.PCWrite_i) pc_q <= pc_inc;
    end
  end

  assign bus.instr_addr_o = pc_q;
  assign bus.IFID_pc_o    = ifid_pc_q;
  assign bus.IFID_instr_o = ifid_instr_q;
  assign bus.IFID_valid_o = ifid_valid_q;
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;

  fetch_if #(.CNT_W(32)) bus  ();
  fetch_if #(.CNT_W(3))  bus2 ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(3)) dut_wrap (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus2.slave)
  );

  // Instruction memory: word i holds 0x100+i.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h100 + (addr >> 2);
  endfunction

  assign bus.instr_i  = mem_word(bus.instr_addr_o);
  assign bus2.instr_i = mem_word(bus2.instr_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Scoreboard entry: expected outputs after one clock edge.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] ifpc;
    logic [31:0] ifinstr;
    logic        valid;
    logic [31:0] sc;
    logic [31:0] fc;
    bit          chk_pc;
  } exp_t;

  exp_t sb[$];

  // Reference model state for the main DUT.
  logic [31:0] m_pc, m_ifpc, m_ifinstr, m_sc, m_fc;
  logic        m_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_ifinstr = NOP; m_valid = 1'b0;
    m_sc = 32'h0; m_fc = 32'h0;
  endtask

  task automatic check_state(input string pfx, input exp_t e);
    check({pfx, "_addr"},  bus.instr_addr_o, e.addr);
    if (e.chk_pc) check({pfx, "_ifpc"}, bus.IFID_pc_o, e.ifpc);
    check({pfx, "_instr"}, bus.IFID_instr_o, e.ifinstr);
    check({pfx, "_valid"}, 32'(bus.IFID_valid_o), 32'(e.valid));
    check({pfx, "_stall"}, bus.stall_cnt_o, e.sc);
    check({pfx, "_flush"}, bus.flush_cnt_o, e.fc);
  endtask

  // Drive one cycle of controls, predict the result, then compare after the edge.
  task automatic step(input logic start, input logic pcw, input logic stall,
                      input logic flush, input logic [31:0] bt);
    exp_t e;
    bus.start_i        = start;
    bus.PCWrite_i      = pcw;
    bus.Stall_i        = stall;
    bus.Flush_i        = flush;
    bus.BranchTarget_i = bt;
    e.chk_pc = 1'b1;
    if (!start) begin
      m_valid   = 1'b0;
      m_ifinstr = NOP;
      e.chk_pc  = 1'b0;
    end else if (stall) begin
      if (pcw) m_pc = m_pc + 32'd4;
      if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
    end else if (flush) begin
      m_ifpc = m_pc; m_ifinstr = NOP; m_valid = 1'b0;
      if (pcw) m_pc = {bt[31:2], 2'b00};
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
    end else begin
      m_ifpc = m_pc; m_ifinstr = mem_word(m_pc); m_valid = 1'b1;
      if (pcw) m_pc = m_pc + 32'd4;
    end
    e.addr = m_pc; e.ifpc = m_ifpc; e.ifinstr = m_ifinstr;
    e.valid = m_valid; e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) check("sb_underflow", 32'h0, 32'h1);
    else check_state("sb", sb.pop_front());
  endtask

  task automatic step2(input logic start, input logic pcw, input logic stall);
    bus2.start_i   = start;
    bus2.PCWrite_i = pcw;
    bus2.Stall_i   = stall;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t r;
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.PCWrite_i = 1'b0; bus.Stall_i = 1'b0;
    bus.Flush_i = 1'b0; bus.BranchTarget_i = 32'h0;
    bus2.start_i = 1'b0; bus2.PCWrite_i = 1'b0; bus2.Stall_i = 1'b0;
    bus2.Flush_i = 1'b0; bus2.BranchTarget_i = 32'h0;
    model_reset();

    // Reset values (checked directly against constants).
    #12;
    r = '{addr: 32'h0, ifpc: 32'h0, ifinstr: NOP, valid: 1'b0,
          sc: 32'h0, fc: 32'h0, chk_pc: 1'b1};
    check_state("rst", r);
    check("rst_wrap_addr", bus2.instr_addr_o, 32'hFFFF_FFF8);
    rst_n = 1'b1;

    // Sequential fetch.
    step(1, 1, 0, 0, 0);
    check("seq_addr1", bus.instr_addr_o, 32'h4);
    check("seq_instr1", bus.IFID_instr_o, 32'h100);
    step(1, 1, 0, 0, 0);
    check("seq_instr2", bus.IFID_instr_o, 32'h101);

    // Load-use stall at PC=8.
    step(1, 0, 1, 0, 0);
    check("lu_addr", bus.instr_addr_o, 32'h8);
    check("lu_ifpc", bus.IFID_pc_o, 32'h4);
    check("lu_stall", bus.stall_cnt_o, 32'h1);
    step(1, 1, 0, 0, 0);
    check("lu_resume", bus.IFID_instr_o, 32'h102);
    step(1, 1, 0, 0, 0);

    // Flush at PC=0x10 to 0x43.
    check("fl_pc_before", bus.instr_addr_o, 32'h10);
    step(1, 1, 0, 1, 32'h43);
    check("fl_addr", bus.instr_addr_o, 32'h40);
    check("fl_valid", 32'(bus.IFID_valid_o), 32'h0);
    check("fl_instr", bus.IFID_instr_o, NOP);
    check("fl_cnt", bus.flush_cnt_o, 32'h1);
    step(1, 1, 0, 0, 0);
    check("fl_next_ifpc", bus.IFID_pc_o, 32'h40);

    // Stall + flush together: flush ignored.
    step(1, 0, 1, 1, 32'h80);
    check("sf_addr", bus.instr_addr_o, 32'h44);
    check("sf_flush", bus.flush_cnt_o, 32'h1);
    check("sf_stall", bus.stall_cnt_o, 32'h2);

    // Unusual combinations.
    step(1, 1, 1, 0, 0);        // stall while PC advances
    step(1, 0, 0, 1, 32'h200);  // flush with PC held
    step(1, 0, 0, 0, 0);        // load with PC held
    step(0, 1, 1, 1, 32'h300);  // frozen: everything holds, bubble
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // Randomised control mix.
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           $urandom());
    end

    // Reset dropped between edges.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    r = '{addr: 32'h0, ifpc: 32'h0, ifinstr: NOP, valid: 1'b0,
          sc: 32'h0, fc: 32'h0, chk_pc: 1'b1};
    check_state("mid_rst", r);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_valid", 32'(bus.IFID_valid_o), 32'h0);
    check("post_rst_addr", bus.instr_addr_o, 32'h0);
    step(1, 1, 0, 0, 0);
    check("post_rst_ifinstr", bus.IFID_instr_o, 32'h100);

    // Wrap-around PC and 3-bit counter saturation on the second instance.
    bus.start_i = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("wrap_a0", bus2.instr_addr_o, 32'hFFFF_FFF8);
    step2(1, 1, 0);
    check("wrap_a1", bus2.instr_addr_o, 32'hFFFF_FFFC);
    step2(1, 1, 0);
    check("wrap_a2", bus2.instr_addr_o, 32'h0000_0000);
    check("wrap_ifpc", bus2.IFID_pc_o, 32'hFFFF_FFFC);
    for (int i = 0; i < 10; i++) begin
      step2(1, 0, 1);
      if (i == 6) check("sat_at7", 32'(bus2.stall_cnt_o), 32'h7);
    end
    check("sat_final", 32'(bus2.stall_cnt_o), 32'h7);
    check("sat_addr_held", bus2.instr_addr_o, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the 5-stage pipeline: owns the PC register and the IF/ID pipeline register, and acts on the stall, PC-hold and flush requests issued by hazard detection and branch resolution in ID. It sits between instruction memory and the decoder. Each cycle it either advances, holds, or inserts a bubble. It also keeps saturating stall and flush event counters for performance measurement.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded at reset; bits [1:0] must be 0.
- CNT_W, 32: width of the stall and flush counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  fetch enable; 0 freezes fetch.
- PCWrite_i  in  1  0 = hold the PC (load-use hazard).
- Stall_i  in  1  1 = hold IF/ID contents.
- Flush_i  in  1  branch taken in ID; squash IF/ID and redirect.
- BranchTarget_i  in  32  redirect address; bits [1:0] ignored.
- instr_i  in  32  instruction memory read data for instr_addr_o, combinational.
- instr_addr_o  out  32  current PC, driven directly from the PC register.
- IFID_pc_o  out  32  PC of the instruction held in IF/ID.
- IFID_instr_o  out  32  instruction held in IF/ID.
- IFID_valid_o  out  1  1 = real instruction; 0 = bubble.
- stall_cnt_o  out  CNT_W  count of stalled cycles.
- flush_cnt_o  out  CNT_W  count of applied flushes.

## Operation
- Reset values, asserted asynchronously while rst_i=0:
  - PC = RESET_PC.
  - IFID_pc_o = 0, IFID_instr_o = 32'h0000_0013 (NOP), IFID_valid_o = 0.
  - Both counters = 0.
- Per-cycle update when start_i=1, in priority order:
  - Stall_i=1:
    - IF/ID holds its contents.
    - Flush_i is ignored, because the branch decision uses stale operands.
    - PC holds if PCWrite_i=0, otherwise PC = PC+4.
    - stall_cnt increments.
  - Stall_i=0, Flush_i=1:
    - IF/ID loads a bubble: instr = NOP, valid = 0, pc = current PC.
    - If PCWrite_i=1, PC = {BranchTarget_i[31:2], 2'b00}; otherwise PC holds.
    - flush_cnt increments.
  - Stall_i=0, Flush_i=0:
    - IF/ID loads {PC, instr_i, valid=1}.
    - If PCWrite_i=1, PC = PC+4; otherwise PC holds.
- When start_i=0:
  - PC holds and counters hold.
  - IF/ID loads a bubble (valid=0, instr = NOP), so downstream stages drain.
- Arithmetic and width rules:
  - PC+4 is computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - PC[1:0] is always 0.
  - Counters saturate at all-ones and never wrap.
- The hazard unit normally drives PCWrite_i=0 together with Stall_i=1; every other combination must still follow the rules above exactly.

## Timing
- instr_addr_o changes only after a clock edge or an asynchronous reset, with no combinational path from any input.
- Fetch latency is one cycle: the instruction at PC appears on IFID_* after the next rising edge.
- A redirect takes effect in one cycle: instr_addr_o = target after the edge where the flush is applied. That same edge places exactly one bubble in IF/ID.
- A stall asserted for N consecutive cycles holds IF/ID for N edges and adds N to stall_cnt.
- Reset mid-operation is not synchronised to the clock, so outputs reach their reset values immediately.
- On the first rising edge after rst_i deasserts with start_i=1:
  - IF/ID captures {RESET_PC, instr_i, valid=1}.
  - PC becomes RESET_PC+4.

## Test plan
- Reset then start_i=1 with memory word i = 0x100+i for 4 cycles -> instr_addr_o = 0,4,8,12. IFID_instr_o lags by one cycle: 0x100,0x101,0x102. IFID_valid_o=1.
- Load-use stall: assert PCWrite_i=0 and Stall_i=1 for 1 cycle at PC=8 -> instr_addr_o stays 8 and IFID stays {4,0x101} for one cycle, then resumes. stall_cnt_o=1.
- Flush with BranchTarget_i=0x43 at PC=0x10 -> next cycle instr_addr_o=0x40, IFID_valid_o=0, IFID_instr_o=0x13, and flush_cnt_o=1. On the following cycle IFID_pc_o=0x40.
- Simultaneous Stall_i=1, Flush_i=1 and PCWrite_i=0 -> PC and IF/ID unchanged, flush_cnt_o unchanged, stall_cnt_o increments.
- With RESET_PC=32'hFFFF_FFF8 -> instr_addr_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. With CNT_W=3 and 10 stall cycles, stall_cnt_o = 7 (saturated).
- Drop rst_i between clock edges mid-run -> all outputs reach reset values before the next edge. After release, fetch restarts at RESET_PC with IFID_valid_o=0 until the first edge.
